// File: rtl/mem_port_arbiter_pkg.sv
// MemoryModesPackage: memory access mode encoding plus the arbiter's
// state and request types shared by mem_port_arbiter and its users.
//   ReadWriteMode : access size for a read or a write (NONE = no access)
//   ArbState_t    : arbiter ownership state (last grantee)
//   MemReq_t      : one complete memory-port request
package MemoryModesPackage;

    // Widest address/data the request struct carries. Module ADDR_W/DATA_W
    // must not exceed these.
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [2:0] {
        ReadWriteMode_NONE     = 3'd0,
        ReadWriteMode_BYTE     = 3'd1,
        ReadWriteMode_HALFWORD = 3'd2,
        ReadWriteMode_WORD     = 3'd3
    } ReadWriteMode;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CPU,
        ARB_LDR
    } ArbState_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] address;
        logic [MEM_DATA_W-1:0] data;
        ReadWriteMode          writeMode;
        ReadWriteMode          readMode;
        logic                  unsignedLoad;
    } MemReq_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the Memory data port between the CPU load/store
// unit (port 0, cpu_*) and the program loader/DMA (port 1, ldr_*).
// One access is issued per cycle; read data comes back the following cycle
// on the owner's rvalid/rdata. Loader bursts are capped at MAX_BURST grants
// while the CPU is waiting.
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   cpu_req/ldr_req           level request, held until the matching gnt
//   *_address/_data/_writeMode/_readMode/_unsignedLoad  request fields
//   cpu_gnt/ldr_gnt           access issued this cycle
//   cpu_rvalid/ldr_rvalid     read data valid (cycle after a read grant)
//   cpu_rdata/ldr_rdata       read data, 0 when not valid for that port
//   mem_*                     request driven to Memory; mem_dataOutput back
//   mode_err                  pulse the cycle after an illegal grant
module mem_port_arbiter
    import MemoryModesPackage::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int CPU_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic [2:0]        cpu_writeMode,
    input  logic [2:0]        cpu_readMode,
    input  logic              cpu_unsignedLoad,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_address,
    input  logic [DATA_W-1:0] ldr_data,
    input  logic [2:0]        ldr_writeMode,
    input  logic [2:0]        ldr_readMode,
    input  logic              ldr_unsignedLoad,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic [2:0]        mem_writeMode,
    output logic [2:0]        mem_readMode,
    output logic              mem_unsignedLoad,
    input  logic [DATA_W-1:0] mem_dataOutput,

    output logic              mode_err
);

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    ArbState_t  state_q, state_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       rd_pending_q, rd_pending_d;
    logic       rd_owner_q, rd_owner_d;     // 0 = CPU, 1 = loader
    logic       err_q, err_d;

    logic       gnt_cpu, gnt_ldr, illegal;
    MemReq_t    cpu_r, ldr_r, sel_r;

    assign cpu_r = '{address:      MEM_ADDR_W'(cpu_address),
                     data:         MEM_DATA_W'(cpu_data),
                     writeMode:    ReadWriteMode'(cpu_writeMode),
                     readMode:     ReadWriteMode'(cpu_readMode),
                     unsignedLoad: cpu_unsignedLoad};

    assign ldr_r = '{address:      MEM_ADDR_W'(ldr_address),
                     data:         MEM_DATA_W'(ldr_data),
                     writeMode:    ReadWriteMode'(ldr_writeMode),
                     readMode:     ReadWriteMode'(ldr_readMode),
                     unsignedLoad: ldr_unsignedLoad};

    // Grant decision. Grants are gated by rst so nothing reaches Memory
    // while reset is held, even with requests pending.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_ldr = 1'b0;
        if (rst) begin
            if (cpu_req && ldr_req) begin
                unique case (state_q)
                    ARB_IDLE: begin
                        if (CPU_FIRST != 0) gnt_cpu = 1'b1;
                        else                gnt_ldr = 1'b1;
                    end
                    ARB_CPU: gnt_ldr = 1'b1;
                    ARB_LDR: begin
                        if (burst_cnt_q < MAX_B) gnt_ldr = 1'b1;
                        else                     gnt_cpu = 1'b1;
                    end
                    default: gnt_cpu = 1'b1;
                endcase
            end else begin
                gnt_cpu = cpu_req;
                gnt_ldr = ldr_req;
            end
        end
    end

    // Request mux onto the Memory port. An illegal read+write request is
    // issued as the write only.
    always_comb begin
        sel_r = '0;
        if (gnt_cpu)      sel_r = cpu_r;
        else if (gnt_ldr) sel_r = ldr_r;
        illegal = (sel_r.writeMode != ReadWriteMode_NONE) &&
                  (sel_r.readMode  != ReadWriteMode_NONE);
        if (illegal) sel_r.readMode = ReadWriteMode_NONE;
    end

    assign mem_address      = sel_r.address[ADDR_W-1:0];
    assign mem_data         = sel_r.data[DATA_W-1:0];
    assign mem_writeMode    = sel_r.writeMode;
    assign mem_readMode     = sel_r.readMode;
    assign mem_unsignedLoad = sel_r.unsignedLoad;

    // Next state: ownership, burst counting, read return tracking.
    always_comb begin
        state_d      = ARB_IDLE;
        burst_cnt_d  = burst_cnt_q;
        rd_pending_d = 1'b0;
        rd_owner_d   = rd_owner_q;
        err_d        = illegal;

        if (gnt_cpu)      state_d = ARB_CPU;
        else if (gnt_ldr) state_d = ARB_LDR;

        // Burst length only matters while the CPU is waiting.
        if (gnt_cpu || !cpu_req)            burst_cnt_d = '0;
        else if (gnt_ldr && burst_cnt_q < MAX_B) burst_cnt_d = burst_cnt_q + 8'd1;

        if (sel_r.readMode != ReadWriteMode_NONE) begin
            rd_pending_d = 1'b1;
            rd_owner_d   = gnt_ldr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            burst_cnt_q  <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            err_q        <= err_d;
        end
    end

    assign cpu_gnt    = gnt_cpu;
    assign ldr_gnt    = gnt_ldr;
    assign cpu_rvalid = rd_pending_q && !rd_owner_q;
    assign ldr_rvalid = rd_pending_q &&  rd_owner_q;
    assign cpu_rdata  = cpu_rvalid ? mem_dataOutput : '0;
    assign ldr_rdata  = ldr_rvalid ? mem_dataOutput : '0;
    assign mode_err   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-addressed Memory stand-in
// (registered read, one cycle latency) and a read-return scoreboard.
module tb_mem_port_arbiter;

    localparam logic [2:0] M_NONE = 3'd0;
    localparam logic [2:0] M_BYTE = 3'd1;
    localparam logic [2:0] M_HALF = 3'd2;
    localparam logic [2:0] M_WORD = 3'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_unsignedLoad, cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_address, cpu_data, cpu_rdata;
    logic [2:0]  cpu_writeMode, cpu_readMode;
    logic        ldr_req, ldr_unsignedLoad, ldr_gnt, ldr_rvalid;
    logic [31:0] ldr_address, ldr_data, ldr_rdata;
    logic [2:0]  ldr_writeMode, ldr_readMode;
    logic [31:0] mem_address, mem_data, mem_dataOutput;
    logic [2:0]  mem_writeMode, mem_readMode;
    logic        mem_unsignedLoad, mode_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8), .CPU_FIRST(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_data(cpu_data),
        .cpu_writeMode(cpu_writeMode), .cpu_readMode(cpu_readMode),
        .cpu_unsignedLoad(cpu_unsignedLoad), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_address(ldr_address), .ldr_data(ldr_data),
        .ldr_writeMode(ldr_writeMode), .ldr_readMode(ldr_readMode),
        .ldr_unsignedLoad(ldr_unsignedLoad), .ldr_gnt(ldr_gnt),
        .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_writeMode(mem_writeMode), .mem_readMode(mem_readMode),
        .mem_unsignedLoad(mem_unsignedLoad), .mem_dataOutput(mem_dataOutput),
        .mode_err(mode_err)
    );

    // Memory stand-in: little-endian bytes, registered read output.
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        logic [15:0] a;
        logic [31:0] r;
        a = mem_address[15:0];
        if (mem_writeMode != M_NONE) begin
            ram[a] <= mem_data[7:0];
            if (mem_writeMode != M_BYTE) ram[a+16'd1] <= mem_data[15:8];
            if (mem_writeMode == M_WORD) begin
                ram[a+16'd2] <= mem_data[23:16];
                ram[a+16'd3] <= mem_data[31:24];
            end
        end
        if (mem_readMode != M_NONE) begin
            case (mem_readMode)
                M_BYTE:  r = mem_unsignedLoad ? {24'd0, ram[a]} : {{24{ram[a][7]}}, ram[a]};
                M_HALF:  r = mem_unsignedLoad ? {16'd0, ram[a+16'd1], ram[a]}
                                              : {{16{ram[a+16'd1][7]}}, ram[a+16'd1], ram[a]};
                default: r = {ram[a+16'd3], ram[a+16'd2], ram[a+16'd1], ram[a]};
            endcase
            mem_dataOutput <= r;
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        owner;   // 0 = CPU, 1 = loader
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input logic owner, input logic [31:0] d);
        exp_t e;
        e.owner = owner; e.data = d; e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv_cpu(input logic req, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] wm, input logic [2:0] rm, input logic u);
        cpu_req = req; cpu_address = a; cpu_data = d;
        cpu_writeMode = wm; cpu_readMode = rm; cpu_unsignedLoad = u;
    endtask

    task automatic drv_ldr(input logic req, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] wm, input logic [2:0] rm, input logic u);
        ldr_req = req; ldr_address = a; ldr_data = d;
        ldr_writeMode = wm; ldr_readMode = rm; ldr_unsignedLoad = u;
    endtask

    // Read-return monitor: every rvalid must match the head of the scoreboard
    // in cycle, owner and data; a due entry with no rvalid is a miss.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_rvalid || ldr_rvalid) begin
            if (sb.size() == 0) begin
                chk("rv_spurious", {30'd0, cpu_rvalid, ldr_rvalid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rv_cycle", cyc, e.cyc);
                chk("rv_owner", 32'(ldr_rvalid), 32'(e.owner));
                chk("rv_both", 32'(cpu_rvalid & ldr_rvalid), 32'd0);
                chk("rv_data", e.owner ? ldr_rdata : cpu_rdata, e.data);
                chk("rv_other_rdata", e.owner ? cpu_rdata : ldr_rdata, 32'd0);
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("rv_missing", {30'd0, cpu_rvalid, ldr_rvalid},
                e.owner ? 32'd1 : 32'd2);
        end
    end

    initial begin
        rst = 1'b0;
        drv_ldr(1'b0, 0, 0, M_NONE, M_NONE, 1'b0);
        // Reset held with a CPU request pending.
        drv_cpu(1'b1, 32'd65532, 32'h22345678, M_WORD, M_NONE, 1'b0);
        mid();
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_mem_wm", 32'(mem_writeMode), 32'(M_NONE));
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_mode_err", 32'(mode_err), 32'd0);

        // Release reset: the pending CPU write is granted immediately.
        nxt(); rst = 1'b1;
        mid();
        chk("wr0_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("wr0_ldr_gnt", 32'(ldr_gnt), 32'd0);
        chk("wr0_addr", mem_address, 32'd65532);
        chk("wr0_data", mem_data, 32'h22345678);
        chk("wr0_wm", 32'(mem_writeMode), 32'(M_WORD));

        nxt(); drv_cpu(1'b1, 32'd65532, 0, M_NONE, M_WORD, 1'b0);
        mid();
        chk("rd0_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd0_rm", 32'(mem_readMode), 32'(M_WORD));
        expect_rd(1'b0, 32'h22345678);

        nxt(); drv_cpu(1'b0, 0, 0, M_NONE, M_NONE, 1'b0);
        mid();
        chk("idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("idle_rm", 32'(mem_readMode), 32'(M_NONE));

        // Both requesting continuously from IDLE: C, then (L x8, C) repeating.
        nxt();
        drv_cpu(1'b1, 32'd4096, 32'hC, M_WORD, M_NONE, 1'b0);
        drv_ldr(1'b1, 32'd4100, 32'hD, M_WORD, M_NONE, 1'b0);
        for (int i = 0; i < 28; i++) begin
            logic want_cpu;
            if (i > 0) nxt();
            mid();
            want_cpu = (i == 0) || (((i - 1) % 9) == 8);
            chk($sformatf("arb_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(want_cpu));
            chk($sformatf("arb_ldr_gnt[%0d]", i), 32'(ldr_gnt), 32'(!want_cpu));
        end
        nxt();
        drv_cpu(1'b0, 0, 0, M_NONE, M_NONE, 1'b0);
        drv_ldr(1'b0, 0, 0, M_NONE, M_NONE, 1'b0);

        // Loader alone: 20 back-to-back word writes.
        for (int i = 0; i < 20; i++) begin
            nxt();
            drv_ldr(1'b1, 32'(4 * i), 32'h1000 + 32'(i), M_WORD, M_NONE, 1'b0);
            mid();
            chk($sformatf("ldr_burst_gnt[%0d]", i), 32'(ldr_gnt), 32'd1);
        end
        nxt();
        drv_ldr(1'b0, 0, 0, M_NONE, M_NONE, 1'b0);
        drv_cpu(1'b1, 32'd16, 0, M_NONE, M_WORD, 1'b0);
        mid();
        chk("rd16_cpu_gnt", 32'(cpu_gnt), 32'd1);
        expect_rd(1'b0, 32'h00001004);

        // Interleaved reads of differently sized/signed data.
        nxt(); drv_cpu(1'b1, 32'd65528, 32'h0000FFFF, M_WORD, M_NONE, 1'b0);
        mid(); chk("wr_ffff_gnt", 32'(cpu_gnt), 32'd1);
        nxt();
        drv_cpu(1'b0, 0, 0, M_NONE, M_NONE, 1'b0);
        drv_ldr(1'b1, 32'd65531, 32'h000000A1, M_BYTE, M_NONE, 1'b0);
        mid(); chk("wr_a1_gnt", 32'(ldr_gnt), 32'd1);
        nxt();
        drv_cpu(1'b1, 32'd65528, 0, M_NONE, M_HALF, 1'b0);
        drv_ldr(1'b1, 32'd65531, 0, M_NONE, M_BYTE, 1'b1);
        mid();
        chk("ilv_ldr_gnt", 32'(ldr_gnt), 32'd1);
        chk("ilv_cpu_wait", 32'(cpu_gnt), 32'd0);
        expect_rd(1'b1, 32'h000000A1);
        nxt(); drv_ldr(1'b0, 0, 0, M_NONE, M_NONE, 1'b0);
        mid();
        chk("ilv_cpu_gnt", 32'(cpu_gnt), 32'd1);
        expect_rd(1'b0, 32'hFFFFFFFF);

        // Illegal read+write request.
        nxt(); drv_cpu(1'b1, 32'd65524, 32'd5, M_WORD, M_WORD, 1'b0);
        mid();
        chk("ill_gnt", 32'(cpu_gnt), 32'd1);
        chk("ill_wm", 32'(mem_writeMode), 32'(M_WORD));
        chk("ill_rm", 32'(mem_readMode), 32'(M_NONE));
        chk("ill_err_early", 32'(mode_err), 32'd0);
        nxt(); drv_cpu(1'b0, 0, 0, M_NONE, M_NONE, 1'b0);
        mid(); chk("ill_err_pulse", 32'(mode_err), 32'd1);
        nxt();
        mid(); chk("ill_err_end", 32'(mode_err), 32'd0);
        nxt(); drv_cpu(1'b1, 32'd65524, 0, M_NONE, M_WORD, 1'b0);
        mid();
        chk("ill_rd_gnt", 32'(cpu_gnt), 32'd1);
        expect_rd(1'b0, 32'd5);

        // Read granted, then reset in the return cycle: no rvalid.
        nxt(); drv_cpu(1'b1, 32'd65524, 0, M_NONE, M_WORD, 1'b0);
        mid(); chk("rst_rd_gnt", 32'(cpu_gnt), 32'd1);
        nxt(); drv_cpu(1'b0, 0, 0, M_NONE, M_NONE, 1'b0); rst = 1'b0;
        mid(); chk("rst_rd_rvalid", 32'(cpu_rvalid), 32'd0);
        nxt(); rst = 1'b1;
        repeat (3) nxt();
        mid();
        chk("end_rvalid", {30'd0, cpu_rvalid, ldr_rvalid}, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
